// File: rtl/mp_add_sequencer_if.sv
// mp_add_sequencer_if: operand/result handshake bundle for the multi-precision add sequencer
interface mp_add_sequencer_if #(parameter int NWORDS = 4);
    localparam int W = 16 * NWORDS;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         busy;
    modport master (
        output in_valid, op_a, op_b, sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, overflow, busy
    );
    modport slave (
        input  in_valid, op_a, op_b, sub, cin, out_ready,
        output in_ready, out_valid, result, cout, overflow, busy
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: multi-precision add/subtract built on one 16-bit ripple-carry word adder, LSW first
module mp_add_sequencer #(
    parameter int NWORDS = 4
) (
    input logic              clk,
    input logic              rst_n,
    mp_add_sequencer_if.slave bus
);
    localparam int IW = $clog2(NWORDS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                  state, state_n;
    logic [NWORDS-1:0][15:0] a_reg, b_reg, res_reg;
    logic                    carry_reg, cout_reg, ovf_reg;
    logic [IW-1:0]           idx;
    logic [15:0]             a_w, b_w, sum_w;
    logic [16:0]             c;
    logic                    last, accept, in_ready, out_valid, busy;
    assign a_w    = a_reg[idx];
    assign b_w    = b_reg[idx];
    assign c[0]   = carry_reg;
    assign last   = idx == IW'(NWORDS - 1);
    assign accept = state == IDLE && bus.in_valid;
    // 16-bit ripple-carry word adder; c[15] and c[16] give the MSB carries for overflow
    for (genvar g = 0; g < 16; g++) begin : g_rca
        assign sum_w[g] = a_w[g] ^ b_w[g] ^ c[g];
        assign c[g+1]   = (a_w[g] & b_w[g]) | (c[g] & (a_w[g] ^ b_w[g]));
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // Next-state and handshake outputs; DONE ignores in_valid so the source must wait for in_ready
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // Operand latch on accept, then one word per cycle with the carry register chaining words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.sub | bus.cin;
            idx       <= '0;
        end else if (state == RUN) begin
            res_reg[idx] <= sum_w;
            carry_reg    <= c[16];
            idx          <= idx + IW'(1);
            if (last) begin
                cout_reg <= c[16];
                ovf_reg  <= c[16] ^ c[15];
            end
        end
    end
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.result    = res_reg;
    assign bus.cout      = cout_reg;
    assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb_mp_add_sequencer: randomized and directed checks of the sequencer against an arithmetic model
module tb_mp_add_sequencer;
    localparam int NW = 4;
    localparam int W  = 16 * NW;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    always #5 clk = ~clk;
    mp_add_sequencer_if #(.NWORDS(NW)) bus();
    mp_add_sequencer #(.NWORDS(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // Returns {overflow, cout, result} from plain W-bit signed/unsigned arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         co, ov;
        if (s) begin
            t  = {1'b0, a} - {1'b0, b};
            r  = t[W-1:0];
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            t  = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            r  = t[W-1:0];
            co = t[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {ov, co, r};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.cout, bus.overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, bus.busy, bus.cout, bus.overflow});
        end
        n_checks++;
        if (bus.result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 0", bus.result);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: in_ready/busy/out_valid got %b want 100", {bus.in_ready, bus.busy, bus.out_valid});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF};
        logic [W-1:0] tb [4] = '{64'h1, 64'h0, 64'h1, 64'h1};
        logic         ts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] er [4] = '{64'h0000_0000_0001_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], ts[i], tc[i]);
            wait_done(lat);
            n_checks++;
            if (lat !== NW || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d (out_valid=%b) want %0d", i, lat, bus.out_valid, NW);
            end
            n_checks++;
            if (bus.result !== er[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: got %h want %h", i, bus.result, er[i]);
            end
            n_checks++;
            if ({bus.cout, bus.overflow} !== {ec[i], eo[i]}) begin
                n_fail++;
                $display("FAIL dir%0d_cout_ovf: got %b want %b", i, {bus.cout, bus.overflow}, {ec[i], eo[i]});
            end
            handshake();
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
                n_fail++;
                $display("FAIL dir%0d_post_hs: out_valid/in_ready/busy got %b want 010", i, {bus.out_valid, bus.in_ready, bus.busy});
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         s, c;
        logic [W+1:0] e;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom);
            c = 1'($urandom);
            e = model(a, b, s, c);
            issue(a, b, s, c);
            wait_done(lat);
            n_checks++;
            if (lat !== NW) begin
                n_fail++;
                $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, NW);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            n_checks++;
            if ({bus.overflow, bus.cout, bus.result} !== e || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_result: a=%h b=%h sub=%b cin=%b got ovf=%b cout=%b res=%h want ovf=%b cout=%b res=%h",
                         i, a, b, s, c, bus.overflow, bus.cout, bus.result, e[W+1], e[W], e[W-1:0]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1 = 64'h1234_5678_9ABC_DEF0, b1 = 64'h0FED_CBA9_8765_4321;
        logic [W-1:0] a2 = 64'hAAAA_0000_5555_FFFF, b2 = 64'h0001_0002_0003_0004;
        logic [W+1:0] e1 = model(a1, b1, 1'b0, 1'b1);
        logic [W+1:0] e2 = model(a2, b2, 1'b1, 1'b0);
        int lat;
        issue(a1, b1, 1'b0, 1'b1);
        wait_done(lat);
        bus.op_a     = a2;
        bus.op_b     = b2;
        bus.sub      = 1'b1;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b10 || {bus.overflow, bus.cout, bus.result} !== e1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid/in_ready=%b res=%h want 10 res=%h", i, {bus.out_valid, bus.in_ready}, bus.result, e1[W-1:0]);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.result !== e1[W-1:0]) begin
            n_fail++;
            $display("FAIL bp_idle: in_ready/out_valid/busy=%b res=%h want 100 res=%h", {bus.in_ready, bus.out_valid, bus.busy}, bus.result, e1[W-1:0]);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_accept: busy/in_ready got %b want 10", {bus.busy, bus.in_ready});
        end
        wait_done(lat);
        n_checks++;
        if (lat !== NW || {bus.overflow, bus.cout, bus.result} !== e2) begin
            n_fail++;
            $display("FAIL bp_second: lat=%0d res=%h cout=%b want lat=%0d res=%h cout=%b", lat, bus.result, bus.cout, NW, e2[W-1:0], e2[W]);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic [W+1:0] e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_ready: got %b want 1", i, bus.in_ready);
            end
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            e = model(a, b, 1'(i), 1'b1);
            issue(a, b, 1'(i), 1'b1);
            wait_done(lat);
            n_checks++;
            if (lat !== NW || {bus.overflow, bus.cout, bus.result} !== e) begin
                n_fail++;
                $display("FAIL b2b%0d_result: lat=%0d res=%h want lat=%0d res=%h", i, lat, bus.result, NW, e[W-1:0]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W+1:0] e = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        int lat;
        issue(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.result === '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_partial: res=%h busy=%b want nonzero partial and busy=1", bus.result, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00 || bus.result !== '0) begin
            n_fail++;
            $display("FAIL mid_run_reset: out_valid/busy=%b res=%h want 00 res=0", {bus.out_valid, bus.busy}, bus.result);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_run_release: in_ready/busy/out_valid got %b want 100", {bus.in_ready, bus.busy, bus.out_valid});
        end
        issue(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== NW || {bus.overflow, bus.cout, bus.result} !== e) begin
            n_fail++;
            $display("FAIL mid_run_recover: lat=%0d res=%h want lat=%0d res=%h", lat, bus.result, NW, e[W-1:0]);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
